// File: rtl/sad_best_match_pkg.sv
// rtl/sad_best_match_pkg.sv - shared types, constants and width helpers for the SAD best-match search
package sad_best_match_pkg;

  // Search controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Default accumulator latency: en sampled -> output reflects that issue
  localparam int LAT_DEF = 2;

  // Accumulator output width for a given pixel width
  function automatic int sad_w(input int width);
    return width + 8;
  endfunction

  // Index width for a count of n items, never narrower than one bit
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sad_best_match_if.sv
// rtl/sad_best_match_if.sv - search control, fetcher/accumulator and result signals of sad_best_match
//   master: environment side (drives start, pix_valid, sad_in)
//   slave : search block side (drives afd_*, cand_idx, pair_idx, busy, done, best_*)
interface sad_best_match_if
  import sad_best_match_pkg::*;
#(
  parameter int SAD_W  = 16,
  parameter int N_CAND = 16,
  parameter int PAIRS  = 32
);
  localparam int CW = idx_w(N_CAND);
  localparam int PW = idx_w(PAIRS);

  logic             start;
  logic             pix_valid;
  logic [SAD_W-1:0] sad_in;
  logic             afd_en;
  logic             afd_acum;
  logic [CW-1:0]    cand_idx;
  logic [PW-1:0]    pair_idx;
  logic             busy;
  logic             done;
  logic [CW-1:0]    best_idx;
  logic [SAD_W-1:0] best_sad;

  modport master (
    output start, pix_valid, sad_in,
    input  afd_en, afd_acum, cand_idx, pair_idx, busy, done, best_idx, best_sad
  );

  modport slave (
    input  start, pix_valid, sad_in,
    output afd_en, afd_acum, cand_idx, pair_idx, busy, done, best_idx, best_sad
  );
endinterface

// File: rtl/sad_cmp_pipe.sv
// rtl/sad_cmp_pipe.sv - LAT-deep candidate tag delay line, strict-less compare and best_* registers
//   clk, rst      clock, synchronous active-low reset
//   push          last pair of a candidate issued this cycle
//   push_cand     candidate index of that issue
//   sad_in        accumulator output
//   init          search start: best_sad<=all-ones, best_idx<=0
//   empty         no tagged entry will remain after this edge
//   best_idx/sad  running winner
module sad_cmp_pipe #(
  parameter int SAD_W = 16,
  parameter int CW    = 4,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [CW-1:0]    push_cand,
  input  logic [SAD_W-1:0] sad_in,
  input  logic             init,
  output logic             empty,
  output logic [CW-1:0]    best_idx,
  output logic [SAD_W-1:0] best_sad
);

  logic [LAT-1:0] vld;
  logic [CW-1:0]  tag [LAT];

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld      <= '0;
      for (int i = 0; i < LAT; i++) tag[i] <= '0;
      best_idx <= '0;
      best_sad <= '0;
    end else begin
      // Shifts every cycle; the accumulator latency is counted in clocks, not issues
      vld[0] <= push;
      tag[0] <= push_cand;
      for (int i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
        tag[i] <= tag[i-1];
      end
      if (init) begin
        best_sad <= '1;
        best_idx <= '0;
      end else if (vld[LAT-1] && (sad_in < best_sad)) begin
        // Strict compare: a tie never displaces the earlier (lower) index
        best_sad <= sad_in;
        best_idx <= tag[LAT-1];
      end
    end
  end

  // The last stage is consumed at this edge, so only earlier stages keep the line busy
  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < LAT - 1; i++) begin
      if (vld[i]) empty = 1'b0;
    end
  end

endmodule

// File: rtl/sad_best_match.sv
// rtl/sad_best_match.sv - sequences candidates through the SAD accumulator and reports the lowest SAD
//   clk, rst  clock, synchronous active-low reset
//   bus       sad_best_match_if.slave: start/pix_valid/sad_in in; afd_en, afd_acum,
//             cand_idx, pair_idx, busy, done, best_idx, best_sad out
module sad_best_match
  import sad_best_match_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SAD_W  = sad_w(WIDTH),
  parameter int N_CAND = 16,
  parameter int PAIRS  = 32,
  parameter int LAT    = LAT_DEF
) (
  input logic              clk,
  input logic              rst,
  sad_best_match_if.slave  bus
);

  localparam int CW = idx_w(N_CAND);
  localparam int PW = idx_w(PAIRS);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_RUN   = 2'(RUN);
  localparam logic [1:0] ST_DRAIN = 2'(DRAIN);
  localparam logic [1:0] ST_DONE  = 2'(DONE);

  localparam logic [CW-1:0] CAND_LAST = CW'(N_CAND - 1);
  localparam logic [PW-1:0] PAIR_LAST = PW'(PAIRS - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cand;
  logic [PW-1:0]    pair;
  logic             issue;
  logic             last_issue;
  logic             init;
  logic             pipe_empty;
  logic [CW-1:0]    best_idx;
  logic [SAD_W-1:0] best_sad;

  assign issue      = (state == ST_RUN) && bus.pix_valid;
  assign last_issue = issue && (pair == PAIR_LAST);
  assign init       = (state == ST_IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      cand  <= '0;
      pair  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state <= ST_RUN;
            cand  <= '0;
            pair  <= '0;
          end
        end
        ST_RUN: begin
          if (issue) begin
            if (pair == PAIR_LAST) begin
              pair <= '0;
              if (cand == CAND_LAST) begin
                cand  <= '0;
                state <= ST_DRAIN;
              end else begin
                cand <= cand + CW'(1);
              end
            end else begin
              pair <= pair + PW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (pipe_empty) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sad_cmp_pipe #(
    .SAD_W (SAD_W),
    .CW    (CW),
    .LAT   (LAT)
  ) u_cmp (
    .clk       (clk),
    .rst       (rst),
    .push      (last_issue),
    .push_cand (cand),
    .sad_in    (bus.sad_in),
    .init      (init),
    .empty     (pipe_empty),
    .best_idx  (best_idx),
    .best_sad  (best_sad)
  );

  assign bus.afd_en   = issue;
  // Pair 0 restarts the sum; the accumulator holds it across pix_valid gaps
  assign bus.afd_acum = (state == ST_RUN) && (pair != '0);
  assign bus.cand_idx = cand;
  assign bus.pair_idx = pair;
  assign bus.busy     = (state == ST_RUN) || (state == ST_DRAIN);
  assign bus.done     = (state == ST_DONE);
  assign bus.best_idx = best_idx;
  assign bus.best_sad = best_sad;

endmodule

// File: tb/tb_sad_best_match.sv
// tb/tb_sad_best_match.sv - self-checking bench for sad_best_match with a behavioural accumulator
module tb_sad_best_match;

  localparam int NC = 4;
  localparam int NP = 4;
  localparam int LT = 2;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sad_best_match_if #(.SAD_W(SW), .N_CAND(NC), .PAIRS(NP)) bus ();

  sad_best_match #(
    .WIDTH  (8),
    .N_CAND (NC),
    .PAIRS  (NP),
    .LAT    (LT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Accumulator model: running sum updated on en, seen on sad_in LT cycles after the issue
  logic [SW-1:0] contrib [NC][NP];
  logic [SW-1:0] acc     = '0;
  logic [SW-1:0] acc_out = '0;
  logic [SW-1:0] acc_nxt;

  always_comb begin
    acc_nxt = acc;
    if (bus.afd_en)
      acc_nxt = (bus.afd_acum ? acc : '0) + contrib[bus.cand_idx][bus.pair_idx];
  end

  always @(posedge clk) begin
    acc     <= acc_nxt;
    acc_out <= acc;
  end

  assign bus.sad_in = acc_out;

  // Expectations for the current cycle, written by the stimulus, read by the compare process
  int            checks = 0;
  int            errors = 0;
  int            cur_t;
  logic          chk = 1'b0;
  logic          exp_run, exp_en, exp_acum, exp_busy, exp_done, exp_best_v;
  int            exp_cand, exp_pair, exp_bidx;
  logic [SW-1:0] exp_bsad;
  logic          lit_on = 1'b0;
  int            lit_idx, lit_done_t;
  logic [SW-1:0] lit_sad;
  logic [SW-1:0] sads [NC];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0d required=%0d", nm, cur_t, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      cmp("busy",   32'(bus.busy),   32'(exp_busy));
      cmp("afd_en", 32'(bus.afd_en), 32'(exp_en));
      cmp("done",   32'(bus.done),   32'(exp_done));
      if (exp_en)  cmp("afd_acum", 32'(bus.afd_acum), 32'(exp_acum));
      if (exp_run) begin
        cmp("cand_idx", 32'(bus.cand_idx), exp_cand);
        cmp("pair_idx", 32'(bus.pair_idx), exp_pair);
      end
      if (exp_best_v) begin
        cmp("best_idx", 32'(bus.best_idx), exp_bidx);
        cmp("best_sad", 32'(bus.best_sad), 32'(exp_bsad));
      end
      if (lit_on && exp_done) begin
        cmp("lit_done_cycle", cur_t, lit_done_t);
        cmp("lit_best_idx", 32'(bus.best_idx), lit_idx);
        cmp("lit_best_sad", 32'(bus.best_sad), 32'(lit_sad));
      end
    end
  end

  task automatic set_sads(input int a, input int b, input int c, input int d);
    sads[0] = SW'(a); sads[1] = SW'(b); sads[2] = SW'(c); sads[3] = SW'(d);
  endtask

  task automatic set_lit(input int idx, input int sad, input int dt);
    lit_on = 1'b1; lit_idx = idx; lit_sad = SW'(sad); lit_done_t = dt;
  endtask

  // gap_mode 0: pix_valid always high; 1: low every 3rd cycle; 2: random
  // abort_t >= 0: rst low in that cycle; e1..e3: extra start pulses
  task automatic run_search(input int gap_mode, input int abort_t,
                            input int e1, input int e2, input int e3);
    int            n, t, t_last, bi;
    logic [SW-1:0] bs;
    logic          pv, fin, run;
    // Split each SAD over the pairs so pair 0 carries most of it
    for (int c = 0; c < NC; c++) begin
      contrib[c][0] = sads[c] - SW'(8 * (NP - 1));
      for (int p = 1; p < NP; p++) contrib[c][p] = SW'(8);
    end
    bs = '1; bi = 0;
    for (int c = 0; c < NC; c++) if (sads[c] < bs) begin bs = sads[c]; bi = c; end
    n = 0; t = 0; t_last = -1; fin = 1'b0;
    while (!fin) begin
      @(posedge clk); #1;
      cur_t = t;
      case (gap_mode)
        1:       pv = (t % 3) != 2;
        2:       pv = (t > 200) || ($urandom_range(0, 3) != 0);
        default: pv = 1'b1;
      endcase
      bus.pix_valid = pv;
      bus.start     = (t == 0) || (t == e1) || (t == e2) || (t == e3);
      rst           = (t != abort_t);
      run        = (t >= 1) && (n < NC * NP) && !(abort_t >= 0 && t > abort_t);
      exp_run    = run;
      exp_en     = run && pv;
      exp_cand   = n / NP;
      exp_pair   = n % NP;
      exp_acum   = (n % NP) != 0;
      exp_busy   = run || (t_last >= 0 && t <= t_last + LT);
      exp_done   = (t_last >= 0) && (t == t_last + LT + 1);
      exp_best_v = (t_last >= 0) && (t >= t_last + LT + 1);
      exp_bidx   = bi;
      exp_bsad   = bs;
      if (abort_t >= 0 && t == abort_t + 1) begin
        exp_best_v = 1'b1; exp_bidx = 0; exp_bsad = '0;
        fin = 1'b1;
      end
      chk = 1'b1;
      if (exp_en) begin
        n++;
        if (n == NC * NP) t_last = t;
      end
      if (t_last >= 0 && t == t_last + LT + 4) fin = 1'b1;
      t++;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.pix_valid = 1'b0;
    for (int c = 0; c < NC; c++) for (int p = 0; p < NP; p++) contrib[c][p] = '0;
    @(posedge clk); #1;
    cur_t = 0;
    exp_run = 1'b0; exp_en = 1'b0; exp_acum = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
    exp_cand = 0; exp_pair = 0;
    exp_best_v = 1'b1; exp_bidx = 0; exp_bsad = '0;
    chk = 1'b1;
    @(negedge clk); #1;
    rst = 1'b1;

    set_sads(40, 24, 56, 32);    set_lit(1, 24, 19);
    run_search(0, -1, -1, -1, -1);
    set_sads(24, 24, 80, 24);    set_lit(0, 24, 19);
    run_search(0, -1, -1, -1, -1);
    set_sads(40, 24, 56, 32);    set_lit(1, 24, 27);
    run_search(1, -1, -1, -1, -1);
    lit_on = 1'b0;
    run_search(0, 6, -1, -1, -1);
    set_lit(1, 24, 19);
    run_search(0, -1, -1, -1, -1);
    run_search(0, -1, 3, 18, 19);
    set_sads(65528, 65528, 65528, 65520); set_lit(3, 65520, 19);
    run_search(0, -1, -1, -1, -1);
    lit_on = 1'b0;
    set_sads(65528, 65528, 65528, 65528);
    run_search(0, -1, -1, -1, -1);
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < NC; c++)
        sads[c] = SW'(8 * $urandom_range(3, (r % 2) ? 10 : 8191));
      run_search(2, -1, -1, -1, -1);
    end

    @(negedge clk); #1;
    chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
